// File: rtl/corelet_seq_if.sv
// rtl/corelet_seq_if.sv - Command, corelet and memory-strobe bundle of the tile sequencer
interface corelet_seq_if #(
  parameter int KIJ_BW = 4,
  parameter int LEN_BW = 8,
  parameter int AW     = 11
);
  logic              i_start;
  logic [KIJ_BW-1:0] i_cfg_nkij;
  logic [LEN_BW-1:0] i_cfg_len;
  logic              i_l0_o_full;
  logic              i_ofifo_valid;
  logic [33:0]       o_inst;
  logic              o_wmem_rd;
  logic              o_xmem_rd;
  logic [AW-1:0]     o_mem_addr;
  logic              o_psum_wr;
  logic              o_psum_acc;
  logic [AW-1:0]     o_psum_addr;
  logic              o_busy;
  logic              o_done;

  // master is the sequencer; slave is the command/corelet/memory side
  modport master (
    input  i_start, i_cfg_nkij, i_cfg_len, i_l0_o_full, i_ofifo_valid,
    output o_inst, o_wmem_rd, o_xmem_rd, o_mem_addr, o_psum_wr, o_psum_acc,
           o_psum_addr, o_busy, o_done
  );

  modport slave (
    output i_start, i_cfg_nkij, i_cfg_len, i_l0_o_full, i_ofifo_valid,
    input  o_inst, o_wmem_rd, o_xmem_rd, o_mem_addr, o_psum_wr, o_psum_acc,
           o_psum_addr, o_busy, o_done
  );
endinterface

// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - Convolution-tile sequencer driving the corelet inst bus and memory strobes
module corelet_seq #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int KIJ_BW = 4,
  parameter int LEN_BW = 8,
  parameter int AW     = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  corelet_seq_if.master bus
);
  localparam int DW = $clog2(ROW + COL + 1);
  localparam int CW = (LEN_BW > DW) ? LEN_BW : DW;
  localparam logic [CW-1:0] C_COL      = CW'(COL);
  localparam logic [CW-1:0] C_COL_M1   = CW'(COL - 1);
  localparam logic [CW-1:0] C_DRAIN_M1 = CW'(ROW + COL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_FILL, S_W_LOAD, S_W_DRAIN, S_X_FILL, S_EXEC, S_OF_DRAIN, S_DONE
  } state_t;

  state_t            r_state;
  logic [KIJ_BW-1:0] r_nkij;
  logic [LEN_BW-1:0] r_len;
  logic [KIJ_BW-1:0] r_kij;
  logic [AW-1:0]     r_base;
  logic [CW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_k_load, r_exec, r_l0_wr, r_l0_rd, r_of_rd;
  logic              r_wmem_rd, r_xmem_rd, r_psum_wr, r_psum_acc;
  logic [AW-1:0]     r_mem_addr, r_psum_addr;
  logic              r_busy, r_done;

  logic [CW-1:0]     w_len;
  logic [CW-1:0]     w_fill_lim;
  logic              w_fill_wr_last;
  logic              w_can_rd;
  logic [CW-1:0]     w_of_cnt;
  logic              w_of_last;
  logic [AW-1:0]     w_next_base;
  logic [KIJ_BW-1:0] w_kij_inc;
  logic              w_acc;

  // r_idx is the next read index; r_cnt counts completed writes, reads or phase cycles
  assign w_len          = CW'(r_len);
  assign w_fill_lim     = (r_state == S_X_FILL) ? w_len : C_COL;
  assign w_fill_wr_last = r_l0_wr && (r_cnt == w_fill_lim - CW'(1));
  assign w_can_rd       = (r_idx < w_fill_lim) && !bus.i_l0_o_full;
  assign w_of_cnt       = r_cnt + CW'(r_of_rd);
  assign w_of_last      = (w_of_cnt == w_len);
  assign w_next_base    = r_base + AW'(COL);
  assign w_kij_inc      = r_kij + KIJ_BW'(1);
  assign w_acc          = (r_kij != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_nkij      <= '0;
      r_len       <= '0;
      r_kij       <= '0;
      r_base      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_k_load    <= 1'b0;
      r_exec      <= 1'b0;
      r_l0_wr     <= 1'b0;
      r_l0_rd     <= 1'b0;
      r_of_rd     <= 1'b0;
      r_wmem_rd   <= 1'b0;
      r_xmem_rd   <= 1'b0;
      r_psum_wr   <= 1'b0;
      r_psum_acc  <= 1'b0;
      r_mem_addr  <= '0;
      r_psum_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wmem_rd  <= 1'b0;
      r_xmem_rd  <= 1'b0;
      r_l0_wr    <= 1'b0;
      r_of_rd    <= 1'b0;
      r_psum_wr  <= 1'b0;
      r_psum_acc <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_nkij     <= bus.i_cfg_nkij;
            r_len      <= bus.i_cfg_len;
            r_kij      <= '0;
            r_base     <= '0;
            r_busy     <= 1'b1;
            r_wmem_rd  <= 1'b1;
            r_mem_addr <= '0;
            r_idx      <= CW'(1);
            r_cnt      <= '0;
            r_state    <= S_W_FILL;
          end
        end
        S_W_FILL, S_X_FILL: begin
          // SRAM data arrives one cycle after the read, so the L0 write trails it
          r_l0_wr <= r_wmem_rd | r_xmem_rd;
          if (r_l0_wr) r_cnt <= r_cnt + CW'(1);
          if (w_fill_wr_last) begin
            r_cnt   <= '0;
            r_l0_rd <= 1'b1;
            if (r_state == S_W_FILL) begin
              r_k_load <= 1'b1;
              r_state  <= S_W_LOAD;
            end else begin
              r_exec  <= 1'b1;
              r_state <= S_EXEC;
            end
          end else if (w_can_rd) begin
            r_idx <= r_idx + CW'(1);
            if (r_state == S_W_FILL) begin
              r_wmem_rd  <= 1'b1;
              r_mem_addr <= r_base + AW'(r_idx);
            end else begin
              r_xmem_rd  <= 1'b1;
              r_mem_addr <= AW'(r_idx);
            end
          end
        end
        S_W_LOAD: begin
          if (r_cnt == C_COL_M1) begin
            r_cnt    <= '0;
            r_l0_rd  <= 1'b0;
            r_k_load <= 1'b0;
            r_state  <= S_W_DRAIN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_W_DRAIN: begin
          if (r_cnt == C_DRAIN_M1) begin
            r_cnt      <= '0;
            r_xmem_rd  <= 1'b1;
            r_mem_addr <= '0;
            r_idx      <= CW'(1);
            r_state    <= S_X_FILL;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (r_cnt == w_len - CW'(1)) begin
            r_cnt   <= '0;
            r_l0_rd <= 1'b0;
            r_exec  <= 1'b0;
            r_state <= S_OF_DRAIN;
            if (bus.i_ofifo_valid) begin
              r_of_rd     <= 1'b1;
              r_psum_wr   <= 1'b1;
              r_psum_acc  <= w_acc;
              r_psum_addr <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OF_DRAIN: begin
          r_cnt <= w_of_cnt;
          if (w_of_last) begin
            r_cnt <= '0;
            if (w_kij_inc == r_nkij) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_kij      <= w_kij_inc;
              r_base     <= w_next_base;
              r_wmem_rd  <= 1'b1;
              r_mem_addr <= w_next_base;
              r_idx      <= CW'(1);
              r_state    <= S_W_FILL;
            end
          end else if (bus.i_ofifo_valid) begin
            r_of_rd     <= 1'b1;
            r_psum_wr   <= 1'b1;
            r_psum_acc  <= w_acc;
            r_psum_addr <= AW'(w_of_cnt);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_inst      = {27'b0, r_of_rd, 2'b0, r_l0_rd, r_l0_wr, r_exec, r_k_load};
  assign bus.o_wmem_rd   = r_wmem_rd;
  assign bus.o_xmem_rd   = r_xmem_rd;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_psum_wr   = r_psum_wr;
  assign bus.o_psum_acc  = r_psum_acc;
  assign bus.o_psum_addr = r_psum_addr;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule
